// File: rtl/cell_dispatch_scheduler.sv
// Shares one fixed-latency CellProcessor between several requesters. A round-robin
// arbiter issues cells, a tag pipeline tracks them, and an in-order FIFO returns results.
module cell_dispatch_scheduler #(
   parameter int CELL_W     = 72,
   parameter int PIX_W      = 8,
   parameter int OP_W       = 4,
   parameter int USER_W     = 8,
   parameter int NUM_REQ    = 2,
   parameter int LATENCY    = 4,
   parameter int FIFO_DEPTH = 8,
   localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*CELL_W-1:0] req_cellA,
   input  logic [NUM_REQ*CELL_W-1:0] req_cellB,
   input  logic [NUM_REQ*OP_W-1:0]   req_opcode,
   input  logic [NUM_REQ*USER_W-1:0] req_user,
   output logic [CELL_W-1:0]         core_cellA,
   output logic [CELL_W-1:0]         core_cellB,
   output logic [OP_W-1:0]           core_opcode,
   output logic [USER_W-1:0]         core_user,
   input  logic [PIX_W-1:0]          core_pixel,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [PIX_W-1:0]          rsp_pixel,
   output logic                      busy
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = AW + 1;
   localparam int IDX_W = ID_W + 1;

   logic [ID_W-1:0]   rrPtr_q, rrPtr_d;
   logic [ID_W-1:0]   grantIdx;
   logic [IDX_W-1:0]  candSum;
   logic              grantFound;
   logic              canIssue;
   logic              issue;

   logic [CELL_W-1:0] coreCellA_q, coreCellB_q;
   logic [OP_W-1:0]   coreOpcode_q;
   logic [USER_W-1:0] coreUser_q;

   logic [LATENCY-1:0] tagValid_q;
   logic [ID_W-1:0]    tagId_q [LATENCY];

   logic [PIX_W-1:0]  fifoPix_q [FIFO_DEPTH];
   logic [ID_W-1:0]   fifoId_q  [FIFO_DEPTH];
   logic [AW:0]       wrPtr_q, rdPtr_q;
   logic              fifoEmpty, fifoFull, push, pop;

   logic [CNT_W-1:0]  outstanding_q, outstanding_d;
   logic              busy_q;

   assign canIssue = outstanding_q < CNT_W'(FIFO_DEPTH);

   // Search starts at rrPtr_q; candSum is one bit wider so the wrap never overflows.
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = '0;
      candSum    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         candSum = {1'b0, rrPtr_q} + IDX_W'(k);
         if (candSum >= IDX_W'(NUM_REQ)) begin
            candSum = candSum - IDX_W'(NUM_REQ);
         end
         if (!grantFound && req_valid[candSum[ID_W-1:0]]) begin
            grantFound = 1'b1;
            grantIdx   = candSum[ID_W-1:0];
         end
      end
   end

   assign issue = grantFound & canIssue & rst;

   always_comb begin
      req_ready = '0;
      rrPtr_d   = rrPtr_q;
      if (issue) begin
         req_ready[grantIdx] = 1'b1;
         rrPtr_d = (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rrPtr_q      <= '0;
         coreCellA_q  <= '0;
         coreCellB_q  <= '0;
         coreOpcode_q <= '0;
         coreUser_q   <= '0;
      end else begin
         rrPtr_q <= rrPtr_d;
         if (issue) begin
            coreCellA_q  <= req_cellA[int'(grantIdx)*CELL_W +: CELL_W];
            coreCellB_q  <= req_cellB[int'(grantIdx)*CELL_W +: CELL_W];
            coreOpcode_q <= req_opcode[int'(grantIdx)*OP_W +: OP_W];
            coreUser_q   <= req_user[int'(grantIdx)*USER_W +: USER_W];
         end
      end
   end

   assign core_cellA  = coreCellA_q;
   assign core_cellB  = coreCellB_q;
   assign core_opcode = coreOpcode_q;
   assign core_user   = coreUser_q;

   // Tags shift every cycle so the last stage lines up with the core's fixed latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tagValid_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            tagId_q[i] <= '0;
         end
      end else begin
         tagValid_q[0] <= issue;
         tagId_q[0]    <= grantIdx;
         for (int i = 1; i < LATENCY; i++) begin
            tagValid_q[i] <= tagValid_q[i-1];
            tagId_q[i]    <= tagId_q[i-1];
         end
      end
   end

   assign push      = tagValid_q[LATENCY-1];
   assign fifoEmpty = (wrPtr_q == rdPtr_q);
   assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign pop       = !fifoEmpty && rsp_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         fifoPix_q[wrPtr_q[AW-1:0]] <= core_pixel;
         fifoId_q[wrPtr_q[AW-1:0]]  <= tagId_q[LATENCY-1];
      end
   end

   assign outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr_q       <= '0;
         rdPtr_q       <= '0;
         outstanding_q <= '0;
         busy_q        <= 1'b0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
         outstanding_q <= outstanding_d;
         busy_q        <= (outstanding_d != '0);
      end
   end

   assign rsp_valid = !fifoEmpty;
   assign rsp_pixel = fifoEmpty ? '0 : fifoPix_q[rdPtr_q[AW-1:0]];
   assign rsp_id    = fifoEmpty ? '0 : fifoId_q[rdPtr_q[AW-1:0]];
   assign busy      = busy_q;

   // Credits make this unreachable; a simultaneous pop frees the slot being written.
   assert property (@(posedge clk) disable iff (!rst) !(push && fifoFull && !pop));

endmodule
